// File: rtl/mem_arbiter_if.sv
// Bus bundle between the MIPS core's fetch/load-store ports, the arbiter and the RAM macro.
// The arbiter uses the slave modport; the core/RAM side uses master.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [15:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [15:0]       d_wdata;
    logic              d_ack;
    logic [15:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: D port has priority, I is forced after STARVE_MAX D grants.
// Define MEM_ARBITER_STATS_EN to add the i_stall_cnt / d_grant_cnt outputs.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]  i_stall_cnt,
    output logic [15:0]  d_grant_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q;
    logic              port_d_q;  // 1 = D port granted, 0 = I port
    logic [2:0]        wait_q;
    logic [3:0]        starve_q;
    logic              i_ack_q, d_ack_q, mem_en_q, mem_we_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q, i_rdata_q, d_rdata_q;
    logic              grant_d;

    // Only meaningful in IDLE with at least one request pending.
    assign grant_d = bus.d_req && !(bus.i_req && (starve_q == 4'(STARVE_MAX)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            port_d_q    <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.d_req || bus.i_req) begin
                        port_d_q    <= grant_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_d && bus.d_we;
                        mem_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        mem_wdata_q <= grant_d ? bus.d_wdata : 16'h0000;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                        if (!grant_d) begin
                            starve_q <= '0;
                        end else if (bus.i_req && (starve_q != 4'(STARVE_MAX))) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end
                end
                StIssue: begin
                    // mem_we_q still holds this access's write flag during ISSUE.
                    if (mem_we_q) begin
                        i_ack_q <= !port_d_q;
                        d_ack_q <= port_d_q;
                        state_q <= StResp;
                    end else begin
                        wait_q  <= 3'(READ_LAT - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (wait_q == 3'd0) begin
                        if (port_d_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end else begin
                            i_rdata_q <= bus.mem_rdata;
                        end
                        i_ack_q <= !port_d_q;
                        d_ack_q <= port_d_q;
                        state_q <= StResp;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                StResp: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] i_stall_q, d_grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_stall_q <= '0;
            d_grant_q <= '0;
        end else begin
            // i_ack_q is high exactly in RESP for an I transaction.
            if (bus.i_req && !i_ack_q && (i_stall_q != 16'hFFFF)) begin
                i_stall_q <= i_stall_q + 16'd1;
            end
            if ((state_q == StIdle) && grant_d && (d_grant_q != 16'hFFFF)) begin
                d_grant_q <= d_grant_q + 16'd1;
            end
        end
    end

    assign i_stall_cnt = i_stall_q;
    assign d_grant_cnt = d_grant_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port 16-bit data memory between the instruction-fetch port (I) and the load/store port (D) of the 16-bit MIPS core.
- Sequences each access as a multi-cycle transaction: issue, fixed read-latency wait, then a response.
- Sits between the core's fetch/memory stages and the RAM macro.
- Data port has fixed priority, with an anti-starvation override for fetch.

Parameters:
- ADDR_W, 12, word address width (matches the 12-bit jump address field).
- READ_LAT, 1, RAM read latency in cycles after mem_en; legal range 1..7.
- STARVE_MAX, 4, consecutive D grants while i_req is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch request, level; held until i_ack.
- i_addr  in  ADDR_W  fetch word address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  16  fetched instruction word.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  16  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  16  load data; valid when d_ack is high for a load.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  16  RAM write data.
- mem_rdata  in  16  RAM read data; valid READ_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, busy.
  - starve_cnt and the wait counter clear to 0.
  - A transaction in flight is abandoned with no ack; requesters must re-issue.
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration happens only in IDLE, on the rising edge:
  - Only d_req high: grant D.
  - Only i_req high: grant I.
  - Both high: grant D unless starve_cnt == STARVE_MAX, in which case grant I.
  - Neither high: stay in IDLE.
  - On a grant, the arbiter latches port id, address, we and wdata, and moves to ISSUE.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each D grant made while i_req is high.
  - Clears to 0 on every I grant.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_addr, mem_we and mem_wdata are driven from the latched values. The I port is always a read.
  - Write: go to RESP.
  - Read: go to WAIT with the wait counter loaded to READ_LAT-1.
  - mem_en and mem_we are 0 in every other state.
- WAIT:
  - Decrement the counter.
  - When the counter is 0, capture mem_rdata into the granted port's rdata register and go to RESP.
  - READ_LAT=1 therefore spends 1 cycle in WAIT.
- RESP (1 cycle):
  - Assert the granted port's ack only; the rdata register is stable.
  - Next state is IDLE unconditionally.
- Latency, counted from the IDLE cycle in which req is sampled (cycle 0):
  - Read: ack in cycle READ_LAT+2.
  - Write: ack in cycle 2.
- Throughput:
  - Back-to-back reads need READ_LAT+3 cycles each.
  - The IDLE cycle after RESP is mandatory.
- Requester rule: drop req, or present a new request, on the edge at which ack is sampled. The arbiter never samples req during ISSUE, WAIT or RESP.
- The rdata registers of the non-granted port hold their previous values.
- Request changes while busy have no effect on the transaction in flight.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: adds outputs i_stall_cnt[15:0] and d_grant_cnt[15:0].
  - i_stall_cnt increments on every cycle in which i_req is high and the state is not RESP-with-I-ack.
  - d_grant_cnt increments on every D grant.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist. Arbitration and timing are identical either way.

Test Plan:
- Reset mid-read: assert rst low during WAIT -> all outputs 0 immediately, no ack; after release with i_req=1, i_addr=12'h010 -> i_ack in cycle 3 (READ_LAT=1) with RAM[0x010].
- Lone load: d_req=1, d_we=0, d_addr=12'h020, RAM[0x020]=16'hBEEF -> mem_en in cycle 1, d_ack and d_rdata=16'hBEEF in cycle 3.
- Lone store: d_we=1, d_addr=12'h005, d_wdata=16'h1234 -> mem_en=mem_we=1 in cycle 1, d_ack in cycle 2; a following load of 0x005 returns 16'h1234.
- Simultaneous requests: i_req and d_req high together -> D served first; I is acked only after the D ack plus the mandatory IDLE cycle.
- Starvation: STARVE_MAX=4, i_req held high, d_req re-asserted continuously -> exactly 4 D grants, then an I grant; starve_cnt is 0 afterwards.
- READ_LAT=3: lone fetch -> mem_en in cycle 1, i_ack in cycle 5; with MEM_ARBITER_STATS_EN defined, i_stall_cnt = 5.
